buzzer_tone_driver: RTL and testbench

BUZZER_TONE_DRIVER -- requirements
Module: buzzer_tone_driver

---
 rtl/buzzer_tone_driver.sv | 132 +++++++++++++
 tb/tb_buzzer_tone_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/buzzer_tone_driver.sv
// Square-wave buzzer driver: note code -> tone at elaboration-time half-periods.
// Optional amplitude envelope compiled in with `define BUZZER_DECAY_EN.
module buzzer_tone_driver #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DECAY_TICKS = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] note,
  output logic       buzzer,
  output logic       busy
);

  function automatic int unsigned hp_of(input int n);
    int unsigned base;
    int unsigned f;
    int unsigned h;
    if (n < 1 || n > 21) return 1;
    case ((n - 1) % 7)
      0: base = 262;
      1: base = 294;
      2: base = 330;
      3: base = 349;
      4: base = 392;
      5: base = 440;
      default: base = 494;
    endcase
    f = base << ((n - 1) / 7);
    h = int'(CLK_FREQ) / (2 * f);
    return (h < 1) ? 1 : h;
  endfunction

  // Note 1 (C4) has the longest half-period, so it bounds the counter.
  localparam int unsigned HP_MAX = hp_of(1);
  localparam int CW = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

  typedef enum logic {IDLE, TONE} state_t;

  logic [CW-1:0] term_tab [32];

  for (genvar i = 0; i < 32; i++) begin : g_tab
    assign term_tab[i] = CW'(hp_of(i) - 1);
  end

  logic [5:0]    note_q;
  state_t        state_q, state_d;
  logic [4:0]    cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          valid, start, gate;

  assign valid = (note_q != 6'd0) && (note_q <= 6'd21);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q  <= '0;
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      note_q  <= note;
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    start   = 1'b0;
    if (!valid) begin
      state_d = IDLE;
      cur_d   = '0;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == IDLE || note_q[4:0] != cur_q) begin
      // Entry or restart: fresh high phase from count 0.
      state_d = TONE;
      cur_d   = note_q[4:0];
      cnt_d   = '0;
      phase_d = 1'b1;
      start   = 1'b1;
    end else if (cnt_q == term_tab[cur_q]) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

`ifdef BUZZER_DECAY_EN
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  logic [3:0]    level_q, pwm_q;
  logic [DW-1:0] dcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      pwm_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      if (!valid) begin
        level_q <= '0;
        dcnt_q  <= '0;
      end else if (start) begin
        level_q <= 4'd15;
        dcnt_q  <= '0;
      end else if (dcnt_q == DW'(DECAY_TICKS - 1)) begin
        dcnt_q <= '0;
        if (level_q > 4'd2) level_q <= level_q - 4'd1;
      end else begin
        dcnt_q <= dcnt_q + DW'(1);
      end
    end
  end

  assign gate = (pwm_q < level_q);
`else
  assign gate = 1'b1;
`endif

  assign busy   = (state_q == TONE);
  assign buzzer = busy & phase_q & gate;

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Directed bench for buzzer_tone_driver with a cycle-level behavioural model
// (note delay + elapsed-time square wave) checked on every falling edge.
module tb_buzzer_tone_driver;

  localparam int CLK_FREQ = 1_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] note = '0;
  logic       buzzer, busy;

  int errors = 0;
  int checks = 0;

  buzzer_tone_driver #(.CLK_FREQ(CLK_FREQ), .DECAY_TICKS(100)) dut (
    .clk(clk), .rst_n(rst_n), .note(note), .buzzer(buzzer), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int freq_of(input int n);
    int b [7] = '{262, 294, 330, 349, 392, 440, 494};
    return b[(n - 1) % 7] * (1 << ((n - 1) / 7));
  endfunction

  function automatic int hp_model(input int n);
    int h;
    h = CLK_FREQ / (2 * freq_of(n));
    return (h < 1) ? 1 : h;
  endfunction

  // Model: what note the DUT has latched, which note is playing, and for how long.
  int  m_nq = 0, m_note = 0, m_t = 0;
  bit  m_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nq = 0; m_note = 0; m_t = 0; m_busy = 0;
    end else begin
      if (m_nq >= 1 && m_nq <= 21) begin
        if (!m_busy || m_nq != m_note) begin
          m_busy = 1; m_note = m_nq; m_t = 0;
        end else m_t++;
      end else begin
        m_busy = 0; m_t = 0;
      end
      m_nq = int'(note);
    end
  end

  function automatic bit exp_buzzer();
    if (!m_busy) return 0;
    return ((m_t / hp_model(m_note)) % 2) == 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
      end
`ifndef BUZZER_DECAY_EN
      checks++;
      if (buzzer !== exp_buzzer()) begin
        errors++;
        $display("FAIL model_buzzer t=%0t got=%b exp=%b", $time, buzzer, exp_buzzer());
      end
`endif
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Counts consecutive falling-edge samples at the given level (bounded).
  task automatic run_len(input bit lvl, output int n);
    n = 0;
    while (buzzer === lvl && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_buzzer", buzzer, 0);

    // Silence held long.
    wait_cycles(5000);
    chk("idle_busy", busy, 0);
    chk("idle_buzzer", buzzer, 0);

    // A4: busy one cycle after note_q, then 1136-cycle phases.
    note = 6'd6;
    @(negedge clk);
    chk("a4_busy_lat1", busy, 0);
    @(negedge clk);
    chk("a4_busy_lat2", busy, 1);
    for (int p = 0; p < 4; p++) begin
      run_len(1'b1, n); chk("a4_high", n, 1136);
      run_len(1'b0, n); chk("a4_low", n, 1136);
    end

    // Switch to C4 mid high phase: restart high for 1908 cycles.
    wait_cycles(500);
    chk("a4_mid_high", buzzer, 1);
    note = 6'd1;
    wait_cycles(2);
    run_len(1'b1, n); chk("c4_restart_high", n, 1908);
    run_len(1'b0, n); chk("c4_low", n, 1908);

    // Out-of-range code is silence.
    note = 6'd40;
    wait_cycles(2);
    chk("oor_busy", busy, 0);
    chk("oor_buzzer", buzzer, 0);
    wait_cycles(200);

    // Silence mid-tone truncates the phase.
    note = 6'd6;
    wait_cycles(300);
    chk("pre_stop_buzzer", buzzer, 1);
    note = 6'd0;
    @(negedge clk);
    chk("stop_lat1_buzzer", buzzer, 1);
    @(negedge clk);
    chk("stop_buzzer", buzzer, 0);
    chk("stop_busy", busy, 0);

    // Asynchronous reset mid-tone.
    note = 6'd6;
    wait_cycles(300);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_buzzer", buzzer, 0);
    chk("arst_busy", busy, 0);
    note = 6'd13;
    wait_cycles(3);
    #2 rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (!busy && n < 10) begin n++; @(negedge clk); end
    chk("a5_start_wait", n, 1);
    run_len(1'b1, n); chk("a5_high", n, 568);
    run_len(1'b0, n); chk("a5_low", n, 568);
    run_len(1'b1, n); chk("a5_high2", n, 568);

    note = 6'd0;
    wait_cycles(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
